// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and pipeline record layout for the hazard controller
package hazard_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // D-stage forward selects
    localparam logic [2:0] FWD_D_RF   = 3'd0;
    localparam logic [2:0] FWD_D_PC8E = 3'd1;
    localparam logic [2:0] FWD_D_PC4M = 3'd2;
    localparam logic [2:0] FWD_D_AOM  = 3'd3;
    localparam logic [2:0] FWD_D_WD   = 3'd4;

    // E-stage forward selects
    localparam logic [1:0] FWD_E_PIPE = 2'd0;
    localparam logic [1:0] FWD_E_AOM  = 2'd1;
    localparam logic [1:0] FWD_E_WD   = 2'd2;
    localparam logic [1:0] FWD_E_PC4M = 2'd3;

    // M-stage forward selects
    localparam logic FWD_M_PIPE = 1'b0;
    localparam logic FWD_M_WD   = 1'b1;

    // Result class of an in-flight instruction
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2,
        CLS_LINK = 2'd3
    } cls_e;

    // One pipeline record; rs/rt are zero when the instruction does not read them
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        cls_e       cls;
    } rec_t;

    // Full decode result for the D-stage instruction
    typedef struct packed {
        rec_t       rec;
        logic       use_rs;
        logic       use_rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
    } dec_t;

    localparam rec_t REC_BUBBLE = '0;

    // Advance a record one stage: its result is one cycle closer to ready
    function automatic rec_t age(input rec_t r);
        rec_t a;
        a = r;
        if (r.tnew != 2'd0) begin
            a.tnew = r.tnew - 2'd1;
        end
        return a;
    endfunction

endpackage

// File: rtl/hazard_ctrl_decode.sv
// rtl/hazard_ctrl_decode.sv - instruction to register-use / result-timing decoder
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    // Classify the instruction; anything unrecognised stays a no-op
    always_comb begin
        dec = '0;
        dec.rec.cls = CLS_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        dec.use_rs   = 1'b1;
                        dec.use_rt   = 1'b1;
                        dec.tuse_rs  = 2'd1;
                        dec.tuse_rt  = 2'd1;
                        dec.rec.dst  = rd;
                        dec.rec.tnew = 2'd1;
                        dec.rec.cls  = CLS_ALU;
                    end
                    FN_SLL: begin
                        dec.use_rt   = 1'b1;
                        dec.tuse_rt  = 2'd1;
                        dec.rec.dst  = rd;
                        dec.rec.tnew = 2'd1;
                        dec.rec.cls  = CLS_ALU;
                    end
                    FN_JR: begin
                        dec.use_rs  = 1'b1;
                        dec.tuse_rs = 2'd0;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.use_rs   = 1'b1;
                dec.tuse_rs  = 2'd1;
                dec.rec.dst  = rt;
                dec.rec.tnew = 2'd1;
                dec.rec.cls  = CLS_ALU;
            end
            OP_LUI: begin
                dec.rec.dst  = rt;
                dec.rec.tnew = 2'd1;
                dec.rec.cls  = CLS_ALU;
            end
            OP_LW: begin
                dec.use_rs   = 1'b1;
                dec.tuse_rs  = 2'd1;
                dec.rec.dst  = rt;
                dec.rec.tnew = 2'd2;
                dec.rec.cls  = CLS_LOAD;
            end
            OP_SW: begin
                dec.use_rs  = 1'b1;
                dec.use_rt  = 1'b1;
                dec.tuse_rs = 2'd1;
                dec.tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                dec.use_rs  = 1'b1;
                dec.use_rt  = 1'b1;
                dec.tuse_rs = 2'd0;
                dec.tuse_rt = 2'd0;
            end
            OP_JAL: begin
                dec.rec.dst  = 5'd31;
                dec.rec.tnew = 2'd0;
                dec.rec.cls  = CLS_LINK;
            end
            default: ;
        endcase
        // Only registers actually read are recorded, so later stages never forward into unused fields
        dec.rec.rs = dec.use_rs ? rs : 5'd0;
        dec.rec.rt = dec.use_rt ? rt : 5'd0;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall and forward-select generation for the 5-stage pipeline
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRD,
    output logic [2:0]  Forward_RS_D_src,
    output logic [2:0]  Forward_RT_D_src,
    output logic [1:0]  Forward_RS_E_src,
    output logic [1:0]  Forward_RT_E_src,
    output logic        Forward_RT_M_src,
    output logic        ClearE,
    output logic        PauseD,
    output logic        PauseF
);

    dec_t dec_d;
    rec_t rec_e;
    rec_t rec_m;
    rec_t rec_w;
    logic stall;
    logic unused_fields;

    hazard_decode u_decode (
        .instr (IRD),
        .dec   (dec_d)
    );

    // A read register stalls when an older result will not be ready by the time it is needed
    function automatic logic needs_stall(input logic [4:0] r, input logic use_r,
                                         input logic [1:0] tuse, input rec_t e, input rec_t m);
        return use_r && (r != 5'd0) &&
               (((r == e.dst) && (tuse < e.tnew)) || ((r == m.dst) && (tuse < m.tnew)));
    endfunction

    // Youngest ready producer wins; a matching record that is not ready is skipped
    function automatic logic [2:0] fwd_d(input logic [4:0] r, input rec_t e, input rec_t m, input rec_t w);
        if (r == 5'd0) return FWD_D_RF;
        if ((r == e.dst) && (e.tnew == 2'd0)) return (e.cls == CLS_LINK) ? FWD_D_PC8E : FWD_D_RF;
        if ((r == m.dst) && (m.tnew == 2'd0)) begin
            if (m.cls == CLS_LINK) return FWD_D_PC4M;
            if (m.cls == CLS_ALU)  return FWD_D_AOM;
            return FWD_D_RF;
        end
        if ((r == w.dst) && (w.tnew == 2'd0)) return FWD_D_WD;
        return FWD_D_RF;
    endfunction

    // A load still in M shadows any older W value, since that W value is stale
    function automatic logic [1:0] fwd_e(input logic [4:0] r, input rec_t m, input rec_t w);
        if (r == 5'd0) return FWD_E_PIPE;
        if (r == m.dst) begin
            if (m.cls == CLS_ALU)  return FWD_E_AOM;
            if (m.cls == CLS_LINK) return FWD_E_PC4M;
            return FWD_E_PIPE;
        end
        if (r == w.dst) return FWD_E_WD;
        return FWD_E_PIPE;
    endfunction

    // Stall detection and forward selects, all combinational from records plus IRD
    always_comb begin
        stall = needs_stall(dec_d.rec.rs, dec_d.use_rs, dec_d.tuse_rs, rec_e, rec_m) ||
                needs_stall(dec_d.rec.rt, dec_d.use_rt, dec_d.tuse_rt, rec_e, rec_m);
        Forward_RS_D_src = fwd_d(dec_d.rec.rs, rec_e, rec_m, rec_w);
        Forward_RT_D_src = fwd_d(dec_d.rec.rt, rec_e, rec_m, rec_w);
        Forward_RS_E_src = fwd_e(rec_e.rs, rec_m, rec_w);
        Forward_RT_E_src = fwd_e(rec_e.rt, rec_m, rec_w);
        Forward_RT_M_src = ((rec_m.rt != 5'd0) && (rec_m.rt == rec_w.dst)) ? FWD_M_WD : FWD_M_PIPE;
    end

    assign PauseF = stall;
    assign PauseD = stall;
    assign ClearE = stall;

    // Fields kept for record symmetry with the datapath but not consulted in later stages
    assign unused_fields = ^{rec_m.rs, rec_w.rs, rec_w.rt, rec_w.cls};

    // Shift the record pipeline; reset flushes every stage, a stall bubbles E
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rec_e <= REC_BUBBLE;
            rec_m <= REC_BUBBLE;
            rec_w <= REC_BUBBLE;
        end else begin
            rec_w <= age(rec_m);
            rec_m <= age(rec_e);
            rec_e <= stall ? REC_BUBBLE : dec_d.rec;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IRD;
    logic [2:0]  Forward_RS_D_src;
    logic [2:0]  Forward_RT_D_src;
    logic [1:0]  Forward_RS_E_src;
    logic [1:0]  Forward_RT_E_src;
    logic        Forward_RT_M_src;
    logic        ClearE;
    logic        PauseD;
    logic        PauseF;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    hazard_ctrl dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IRD              (IRD),
        .Forward_RS_D_src (Forward_RS_D_src),
        .Forward_RT_D_src (Forward_RT_D_src),
        .Forward_RS_E_src (Forward_RS_E_src),
        .Forward_RT_E_src (Forward_RT_E_src),
        .Forward_RT_M_src (Forward_RT_M_src),
        .ClearE           (ClearE),
        .PauseD           (PauseD),
        .PauseF           (PauseF)
    );

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int rsd, input int rtd, input int rse,
                              input int rte, input int rtm, input int stl);
        #1;
        chk({tag, ".rs_d"},   {5'b0, Forward_RS_D_src}, rsd[7:0]);
        chk({tag, ".rt_d"},   {5'b0, Forward_RT_D_src}, rtd[7:0]);
        chk({tag, ".rs_e"},   {6'b0, Forward_RS_E_src}, rse[7:0]);
        chk({tag, ".rt_e"},   {6'b0, Forward_RT_E_src}, rte[7:0]);
        chk({tag, ".rt_m"},   {7'b0, Forward_RT_M_src}, rtm[7:0]);
        chk({tag, ".pausef"}, {7'b0, PauseF}, stl[7:0]);
        chk({tag, ".paused"}, {7'b0, PauseD}, stl[7:0]);
        chk({tag, ".cleare"}, {7'b0, ClearE}, stl[7:0]);
    endtask

    task automatic flush;
        IRD = 32'h0;
        tick();
        tick();
        tick();
    endtask

    logic [31:0] lw1, beq12, addu312, addu433, jal_i, jr31, lw5, sw5, lw0, addu200;
    logic [31:0] ori6, sll762, lui8, beq80, bad_op;

    initial begin
        lw1     = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
        beq12   = i_ins(6'h04, 5'd1, 5'd2, 16'd0);
        addu312 = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        addu433 = r_ins(5'd3, 5'd3, 5'd4, 5'd0, 6'h21);
        jal_i   = {6'h03, 26'h40};
        jr31    = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        lw5     = i_ins(6'h23, 5'd0, 5'd5, 16'd0);
        sw5     = i_ins(6'h2B, 5'd0, 5'd5, 16'd4);
        lw0     = i_ins(6'h23, 5'd0, 5'd0, 16'd0);
        addu200 = r_ins(5'd0, 5'd0, 5'd2, 5'd0, 6'h21);
        ori6    = i_ins(6'h0D, 5'd0, 5'd6, 16'd1);
        sll762  = r_ins(5'd0, 5'd6, 5'd7, 5'd2, 6'h00);
        lui8    = i_ins(6'h0F, 5'd0, 5'd8, 16'd1);
        beq80   = i_ins(6'h04, 5'd8, 5'd0, 16'd0);
        bad_op  = i_ins(6'h3F, 5'd8, 5'd8, 16'd0);

        Reset = 1'b1;
        IRD   = 32'h0;
        tick();
        tick();
        Reset = 1'b0;
        expect_all("reset", 0, 0, 0, 0, 0, 0);

        // load-use into a branch: two stall cycles, then W forward
        IRD = lw1;
        tick();
        IRD = beq12;
        expect_all("lw_beq_c1", 0, 0, 0, 0, 0, 1);
        tick();
        expect_all("lw_beq_c2", 0, 0, 0, 0, 0, 1);
        tick();
        expect_all("lw_beq_c3", 4, 0, 0, 0, 0, 0);
        flush();

        // ALU chain: Tuse equal to Tnew does not stall, then M-ALU forwards
        IRD = addu312;
        tick();
        IRD = addu433;
        expect_all("addu_e", 0, 0, 0, 0, 0, 0);
        tick();
        expect_all("addu_m", 3, 3, 1, 1, 0, 0);
        IRD = 32'h0;
        tick();
        expect_all("addu_w", 0, 0, 0, 0, 1, 0);
        flush();

        // jal followed by jr $31
        IRD = jal_i;
        tick();
        IRD = jr31;
        expect_all("jal_e", 1, 0, 0, 0, 0, 0);
        tick();
        expect_all("jal_m", 2, 0, 3, 0, 0, 0);
        tick();
        expect_all("jal_w", 4, 0, 2, 0, 0, 0);
        flush();

        // lw then sw of the loaded register
        IRD = lw5;
        tick();
        IRD = sw5;
        expect_all("lw_sw_d", 0, 0, 0, 0, 0, 0);
        tick();
        IRD = 32'h0;
        expect_all("lw_sw_e", 0, 0, 0, 0, 0, 0);
        tick();
        expect_all("lw_sw_m", 0, 0, 0, 0, 1, 0);
        flush();

        // writes and reads of $0 are ignored
        IRD = lw0;
        tick();
        IRD = addu200;
        expect_all("zero_d", 0, 0, 0, 0, 0, 0);
        tick();
        IRD = 32'h0;
        expect_all("zero_e", 0, 0, 0, 0, 0, 0);
        flush();

        // ori producing rt consumed by sll
        IRD = ori6;
        tick();
        IRD = sll762;
        expect_all("ori_sll_e", 0, 0, 0, 0, 0, 0);
        tick();
        expect_all("ori_sll_m", 0, 3, 0, 1, 0, 0);
        flush();

        // lui then branch with Tuse 0; unknown opcode decodes to nothing
        IRD = lui8;
        tick();
        IRD = bad_op;
        expect_all("bad_op", 0, 0, 0, 0, 0, 0);
        IRD = beq80;
        expect_all("lui_beq", 0, 0, 0, 0, 0, 1);
        flush();

        // reset in the middle of a load-use stall
        IRD = lw1;
        tick();
        IRD = beq12;
        expect_all("rst_pre", 0, 0, 0, 0, 0, 1);
        Reset = 1'b1;
        IRD   = 32'h0;
        tick();
        Reset = 1'b0;
        expect_all("rst_post", 0, 0, 0, 0, 0, 0);
        IRD = beq12;
        expect_all("rst_flushed", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
